// File: rtl/reflet_delay_var.sv
// Runtime-selectable WIDTH-bit delay line (1..MAX_DELAY enabled cycles), with clock enable and flush.
// Latency: a sample written on enabled edge k is visible on out after enabled edge k+d-1; out is a mux of registers.
// No backpressure: enable only advances the line, and out_valid marks when out holds real history.
module reflet_delay_var #(
    parameter int               WIDTH     = 8,
    parameter int               MAX_DELAY = 16,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             flush,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   delay,
    input  logic [WIDTH-1:0]                 in,
    output logic [WIDTH-1:0]                 out,
    output logic                             out_valid
);

    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    logic [WIDTH-1:0] stage_q [MAX_DELAY];
    logic [WIDTH-1:0] stage_d [MAX_DELAY];
    logic [DW-1:0]    fill_q;
    logic [DW-1:0]    fill_d;
    logic [DW-1:0]    d_eff;
    logic [AW-1:0]    sel;

    always_comb begin
        for (int i = 0; i < MAX_DELAY; i++) begin
            stage_d[i] = stage_q[i];
        end
        fill_d = fill_q;
        // Flush wins over enable; the sample presented on that edge is dropped.
        if (flush) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_d[i] = INIT;
            end
            fill_d = '0;
        end else if (enable) begin
            stage_d[0] = in;
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q != DW'(MAX_DELAY)) begin
                fill_d = fill_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_q[i] <= INIT;
            end
            fill_q <= '0;
        end else begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            fill_q <= fill_d;
        end
    end

    // Out-of-range selects are clamped so out always maps to a real stage.
    always_comb begin
        if (delay == '0) begin
            d_eff = DW'(1);
        end else if (delay > DW'(MAX_DELAY)) begin
            d_eff = DW'(MAX_DELAY);
        end else begin
            d_eff = delay;
        end
        sel = AW'(d_eff - DW'(1));
    end

    assign out       = stage_q[sel];
    assign out_valid = (fill_q >= d_eff);

endmodule

// File: tb/tb_reflet_delay_var.sv
// Directed bench for reflet_delay_var (WIDTH=8, MAX_DELAY=16, INIT=0).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_reflet_delay_var;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       flush;
    logic [4:0] delay;
    logic [7:0] in;
    logic [7:0] out;
    logic       out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    reflet_delay_var #(
        .WIDTH     (8),
        .MAX_DELAY (16),
        .INIT      (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .delay     (delay),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Single 0xAA pulse through a delay of 5 from an empty line.
    task automatic pulse_check(input string tag);
        delay  = 5'd5;
        enable = 1'b1;
        in     = 8'hAA;
        tick();
        in = 8'h00;
        chk({tag, "_edge1_out"}, out, 8'h00);
        chk({tag, "_edge1_vld"}, out_valid, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("%s_edge%0d_out", tag, i + 1), out, (i == 4) ? 8'hAA : 8'h00);
            chk($sformatf("%s_edge%0d_vld", tag, i + 1), out_valid, (i >= 4) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] hist[$];
        int         n_en;

        reset  = 1'b0;
        enable = 1'b0;
        flush  = 1'b0;
        delay  = 5'd1;
        in     = 8'h00;
        #3;
        chk("reset_out", out, 8'h00);
        chk("reset_vld", out_valid, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        chk("post_release_vld", out_valid, 1'b0);

        // T1: delay 1
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in = 8'(i);
            tick();
            chk($sformatf("t1_out%0d", i), out, 8'(i));
            chk($sformatf("t1_vld%0d", i), out_valid, 1'b1);
        end

        // T2: single pulse, delay 5
        do_flush();
        chk("t2_flush_out", out, 8'h00);
        chk("t2_flush_vld", out_valid, 1'b0);
        pulse_check("t2");

        // T3: enable toggling, delay 4, ramp input
        do_flush();
        delay = 5'd4;
        n_en  = 0;
        hist  = {};
        for (int cyc = 0; cyc < 16; cyc++) begin
            enable = (cyc % 2 == 0);
            in     = 8'h10 + 8'(cyc);
            if (enable) begin
                hist.push_back(in);
                n_en++;
            end
            tick();
            chk($sformatf("t3_out_c%0d", cyc), out, (n_en >= 4) ? hist[n_en-4] : 8'h00);
            chk($sformatf("t3_vld_c%0d", cyc), out_valid, (n_en >= 4) ? 1'b1 : 1'b0);
        end

        // T4: full line, delay switched without a clock edge
        do_flush();
        enable = 1'b1;
        delay  = 5'd16;
        for (int i = 0; i < 16; i++) begin
            in = 8'h40 + 8'(i);
            tick();
        end
        enable = 1'b0;
        chk("t4_d16_out", out, 8'h40);
        chk("t4_d16_vld", out_valid, 1'b1);
        delay = 5'd3;
        #1;
        chk("t4_d3_out", out, 8'h4D);
        chk("t4_d3_vld", out_valid, 1'b1);
        delay = 5'd20;
        #1;
        chk("t4_d20_out", out, 8'h40);
        chk("t4_d20_vld", out_valid, 1'b1);
        delay = 5'd0;
        #1;
        chk("t4_d0_out", out, 8'h4F);
        chk("t4_d0_vld", out_valid, 1'b1);
        tick();
        chk("t4_hold_out", out, 8'h4F);

        // T5: flush together with enable at fill 6, delay 10
        do_flush();
        enable = 1'b1;
        delay  = 5'd6;
        for (int i = 0; i < 6; i++) begin
            in = 8'h60 + 8'(i);
            tick();
        end
        chk("t5_fill6_d6_out", out, 8'h60);
        chk("t5_fill6_d6_vld", out_valid, 1'b1);
        delay = 5'd10;
        #1;
        chk("t5_fill6_d10_vld", out_valid, 1'b0);
        flush = 1'b1;
        in    = 8'h99;
        tick();
        flush = 1'b0;
        delay = 5'd1;
        #1;
        chk("t5_flush_out", out, 8'h00);
        chk("t5_flush_vld", out_valid, 1'b0);
        delay = 5'd10;
        for (int i = 0; i < 10; i++) begin
            in = 8'h70 + 8'(i);
            tick();
            chk($sformatf("t5_vld_e%0d", i + 1), out_valid, (i == 9) ? 1'b1 : 1'b0);
        end
        chk("t5_out", out, 8'h70);

        // T6: asynchronous reset mid-stream, then a repeat of the pulse test
        delay = 5'd5;
        #1;
        chk("t6_pre_out", out, 8'h75);
        chk("t6_pre_vld", out_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_out", out, 8'h00);
        chk("t6_async_vld", out_valid, 1'b0);
        enable = 1'b1;
        in     = 8'h55;
        delay  = 5'd1;
        tick();
        chk("t6_held_out", out, 8'h00);
        chk("t6_held_vld", out_valid, 1'b0);
        reset = 1'b1;
        pulse_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
